config_sequencer: RTL

//  Frame-level controller for the JTAG-side bitstream path. Parses a 16-bit header
//  (length[11:0], type[3:0]) from the serial tdi stream, then routes exactly `length`

---
 rtl/config_pkg.sv | 9 +
 rtl/config_header_shift.sv | 31 +++
 rtl/config_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// config_pkg: sequencer states and the 16-bit frame header layout.
package config_pkg;
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, ERROR} state_t;
    localparam int TYPE_W   = 4;
    localparam int LEN_W    = 12;
    localparam int HDR_W    = 16;
    localparam int TYPE_LSB = 0;
    localparam int LEN_LSB  = 4;
endpackage

// File: rtl/config_header_shift.sv
// config_header_shift: collects the serial header MSB first and strobes on its last bit.
module config_header_shift
    import config_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             tdi,
    output logic             hdr_valid,
    output logic [HDR_W-1:0] hdr_word
);
    localparam int CNT_W = $clog2(HDR_W);
    logic [HDR_W-2:0] hdr_q, hdr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign hdr_word  = {hdr_q, tdi};
    assign hdr_valid = shift && cnt_q == CNT_W'(HDR_W - 1);
    // any gap in shifting restarts the bit count, so an aborted header never leaks into the next
    always_comb begin
        hdr_d = shift ? hdr_word[HDR_W-2:0] : hdr_q;
        cnt_d = shift ? cnt_q + CNT_W'(1) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_q <= '0;
            cnt_q <= '0;
        end else begin
            hdr_q <= hdr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/config_sequencer.sv
// config_sequencer: parses a length/type header from tdi and routes the payload to one config chain.
module config_sequencer
    import config_pkg::*;
#(
    parameter int NUM_CHAINS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  tdi,
    input  logic [NUM_CHAINS-1:0] chain_sdo,
    output logic                  tdo,
    output logic [NUM_CHAINS-1:0] chain_en,
    output logic                  chain_sdi,
    output logic [TYPE_W-1:0]     cfg_type,
    output logic [LEN_W-1:0]      cfg_length,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    state_t                  state_q, state_d;
    logic [TYPE_W-1:0]       type_q, type_d;
    logic [LEN_W-1:0]        len_q, len_d, cnt_q, cnt_d;
    logic [NUM_CHAINS-1:0]   chain_en_q, chain_en_d, sel;
    logic                    tdo_q, tdo_d, sdi_q, sdi_d;
    logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                    hdr_valid;
    logic [HDR_W-1:0]        hdr_word;
    logic [TYPE_W-1:0]       hdr_type;
    logic [LEN_W-1:0]        hdr_len;

    config_header_shift u_hdr (
        .clk       (clk),
        .rst       (rst),
        .shift     (en && (state_q == IDLE || state_q == HEADER)),
        .tdi       (tdi),
        .hdr_valid (hdr_valid),
        .hdr_word  (hdr_word)
    );

    assign hdr_type = hdr_word[TYPE_LSB +: TYPE_W];
    assign hdr_len  = hdr_word[LEN_LSB +: LEN_W];
    assign sel      = NUM_CHAINS'(1) << type_q;

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        sdi_d      = sdi_q;
        done_d     = 1'b0;
        chain_en_d = '0;
        tdo_d      = state_q == PAYLOAD ? |(chain_sdo & sel) : (en ? tdi : tdo_q);
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = HEADER;
                    err_d   = 1'b0;
                end
            end
            HEADER: begin
                if (!en) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (hdr_valid) begin
                    type_d = hdr_type;
                    len_d  = hdr_len;
                    if ({1'b0, hdr_type} >= (TYPE_W + 1)'(NUM_CHAINS)) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else if (hdr_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = PAYLOAD;
                        cnt_d   = hdr_len;
                    end
                end
            end
            PAYLOAD: begin
                if (!en) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    sdi_d      = tdi;
                    chain_en_d = sel;
                    cnt_d      = cnt_q != '0 ? cnt_q - LEN_W'(1) : cnt_q;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = HEADER;
                        done_d  = 1'b1;
                    end
                end
            end
            ERROR: begin
                err_d   = 1'b1;
                state_d = en ? ERROR : IDLE;
            end
        endcase
        busy_d = state_d == HEADER || state_d == PAYLOAD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            type_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            chain_en_q <= '0;
            tdo_q      <= 1'b0;
            sdi_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            chain_en_q <= chain_en_d;
            tdo_q      <= tdo_d;
            sdi_q      <= sdi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tdo        = tdo_q;
    assign chain_en   = chain_en_q;
    assign chain_sdi  = sdi_q;
    assign cfg_type   = type_q;
    assign cfg_length = len_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule
